// File: rtl/wbs_mem_ctrl.sv
// wbs_mem_ctrl: Wishbone slave front-end for the accelerator. It decodes the
// register window and four 64-bit SRAM regions, packs 32-bit bus halves into
// SRAM words, and keeps the bus off the SRAMs while the search FSM is busy.
module wbs_mem_ctrl #(
  parameter int          MEM_ADDR_WIDTH = 13,
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_we_i,
  input  logic [3:0]                wbs_sel_i,
  input  logic [31:0]               wbs_adr_i,
  input  logic [31:0]               wbs_dat_i,
  output logic                      wbs_ack_o,
  output logic [31:0]               wbs_dat_o,
  output logic                      mode_o,
  output logic                      debug_o,
  output logic                      fsm_start_o,
  input  logic                      fsm_busy_i,
  input  logic                      fsm_done_i,
  output logic [3:0]                mem_sel_o,
  output logic                      mem_csb_o,
  output logic                      mem_web_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [63:0]               mem_wdata_o,
  input  logic [63:0]               mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_reg;
  logic [31:0] hold_reg;      // lower half waiting for its upper-half partner
  logic        done_reg;      // sticky FSM completion
  logic        conflict_reg;  // sticky "bus hit a busy SRAM"
  logic        rd_pass_reg;   // current ack carries SRAM read data
  logic        rd_half_reg;   // which half of the SRAM word to return
  logic [31:0] dat_reg;       // non-SRAM read data, nonzero only with ack

  // Byte lanes and the sub-word address bits carry no information here.
  logic unused_ok;
  assign unused_ok = ^{wbs_sel_i, wbs_adr_i[1:0]};

  logic       req, base_hit, half, is_reg, is_mem, is_node, mem_to_sram;
  logic [3:0] region;
  logic [2:0] reg_off;
  logic [3:0] sel_dec;

  assign req      = wbs_cyc_i & wbs_stb_i;
  assign base_hit = (wbs_adr_i[31:20] == BASE_ADDR[31:20]);
  assign region   = wbs_adr_i[19:16];
  assign half     = wbs_adr_i[2];
  assign reg_off  = wbs_adr_i[4:2];
  assign is_reg   = base_hit && (region == 4'd0);
  assign is_mem   = base_hit && (region >= 4'd1) && (region <= 4'd4);
  assign is_node  = (region == 4'd4);
  assign sel_dec  = is_mem ? (4'b0001 << (region - 4'd1)) : 4'b0000;

  // Reads always touch the SRAM; node words are written from the lower half
  // alone, the other regions only once the upper half completes the word.
  assign mem_to_sram = is_mem && !fsm_busy_i &&
                       (!wbs_we_i || (is_node ? !half : half));

  // Register-window read mux, sampled in IDLE.
  logic [31:0] reg_rdata;
  always_comb begin
    reg_rdata = 32'b0;
    case (reg_off)
      3'd0:    reg_rdata = {31'b0, mode_o};
      3'd1:    reg_rdata = {31'b0, debug_o};
      3'd2:    reg_rdata = {31'b0, done_reg};
      3'd4:    reg_rdata = {30'b0, conflict_reg, fsm_busy_i};
      default: reg_rdata = 32'b0;
    endcase
  end

  // SRAM read data arrives one cycle after the strobe, i.e. in the ack
  // cycle, so it is steered straight from the SRAM output register.
  assign wbs_dat_o = (rd_pass_reg && wbs_ack_o)
                   ? (rd_half_reg ? mem_rdata_i[63:32] : mem_rdata_i[31:0])
                   : dat_reg;

  // Request FSM with registered bus, SRAM and control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      hold_reg     <= 32'b0;
      done_reg     <= 1'b0;
      conflict_reg <= 1'b0;
      rd_pass_reg  <= 1'b0;
      rd_half_reg  <= 1'b0;
      dat_reg      <= 32'b0;
      wbs_ack_o    <= 1'b0;
      mode_o       <= 1'b0;
      debug_o      <= 1'b0;
      fsm_start_o  <= 1'b0;
      mem_sel_o    <= 4'b0;
      mem_csb_o    <= 1'b1;
      mem_web_o    <= 1'b1;
      mem_addr_o   <= '0;
      mem_wdata_o  <= 64'b0;
    end else begin
      fsm_start_o <= 1'b0;
      // An accepted start below overrides a coincident done.
      if (fsm_done_i) done_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (req) begin
            if (mem_to_sram) begin
              state_reg   <= ACCESS;
              mem_csb_o   <= 1'b0;
              mem_web_o   <= ~wbs_we_i;
              mem_sel_o   <= sel_dec;
              mem_addr_o  <= wbs_adr_i[3 +: MEM_ADDR_WIDTH];
              rd_pass_reg <= ~wbs_we_i;
              rd_half_reg <= half;
              if (wbs_we_i)
                mem_wdata_o <= is_node ? {32'b0, wbs_dat_i} : {wbs_dat_i, hold_reg};
            end else begin
              state_reg <= RESP;
              wbs_ack_o <= 1'b1;
              if (is_mem && fsm_busy_i) begin
                conflict_reg <= 1'b1;
              end else if (is_mem) begin
                // Lower-half write to a packed region; node upper halves drop.
                if (!is_node) hold_reg <= wbs_dat_i;
              end else if (is_reg) begin
                if (wbs_we_i) begin
                  case (reg_off)
                    3'd0: mode_o  <= wbs_dat_i[0];
                    3'd1: debug_o <= wbs_dat_i[0];
                    3'd3: begin
                      if (!fsm_busy_i) begin
                        fsm_start_o <= 1'b1;
                        done_reg    <= 1'b0;
                      end
                    end
                    3'd4: conflict_reg <= 1'b0;
                    default: ;
                  endcase
                end else begin
                  dat_reg <= reg_rdata;
                end
              end
            end
          end
        end
        ACCESS: begin
          mem_csb_o <= 1'b1;
          mem_web_o <= 1'b1;
          mem_sel_o <= 4'b0;
          wbs_ack_o <= 1'b1;
          state_reg <= RESP;
        end
        RESP: begin
          wbs_ack_o   <= 1'b0;
          dat_reg     <= 32'b0;
          rd_pass_reg <= 1'b0;
          state_reg   <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wbs_mem_ctrl.sv
`timescale 1ns/1ps
module tb_wbs_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        mode_o, debug_o, fsm_start_o;
  logic        fsm_busy_i, fsm_done_i;
  logic [3:0]  mem_sel_o;
  logic        mem_csb_o, mem_web_o;
  logic [12:0] mem_addr_o;
  logic [63:0] mem_wdata_o, mem_rdata_i;

  always #5 clk = ~clk;

  wbs_mem_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .mode_o(mode_o), .debug_o(debug_o), .fsm_start_o(fsm_start_o),
    .fsm_busy_i(fsm_busy_i), .fsm_done_i(fsm_done_i),
    .mem_sel_o(mem_sel_o), .mem_csb_o(mem_csb_o), .mem_web_o(mem_web_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  // Default content of a never-written SRAM word, shared by SRAM and model.
  function automatic logic [63:0] dflt(input int r, input int a);
    return {32'(r * 1000 + a), 32'hFACE_0000 + 32'(a)};
  endfunction

  function automatic int region_of(input logic [3:0] sel);
    case (sel)
      4'b0001: return 1;
      4'b0010: return 2;
      4'b0100: return 3;
      4'b1000: return 4;
      default: return 0;
    endcase
  endfunction

  // Behavioural SRAMs with one-cycle registered read.
  logic [63:0] sram_mem [0:4][0:63];
  bit          sram_wr  [0:4][0:63];
  logic [63:0] rdata_q = 64'b0;
  assign mem_rdata_i = rdata_q;
  always @(posedge clk) begin
    if (mem_csb_o === 1'b0 && mem_addr_o < 13'd64) begin
      if (mem_web_o === 1'b0) begin
        sram_mem[region_of(mem_sel_o)][mem_addr_o[5:0]] <= mem_wdata_o;
        sram_wr[region_of(mem_sel_o)][mem_addr_o[5:0]]  <= 1'b1;
      end else begin
        rdata_q <= sram_wr[region_of(mem_sel_o)][mem_addr_o[5:0]]
                 ? sram_mem[region_of(mem_sel_o)][mem_addr_o[5:0]]
                 : dflt(region_of(mem_sel_o), int'(mem_addr_o[5:0]));
      end
    end
  end

  // Reference model state.
  logic [63:0] ref_mem [0:4][0:63];
  logic        m_mode, m_debug, m_done, m_conflict;
  logic [31:0] m_hold;
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] last_wdata;
  logic [12:0] last_addr;
  logic [3:0]  last_sel;
  logic [31:0] rd;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_debug = 0; m_done = 0; m_conflict = 0; m_hold = 32'b0;
  endtask

  task automatic check_reset(input string p);
    chk({p, "_ack"},   wbs_ack_o, 0);
    chk({p, "_dat"},   wbs_dat_o, 0);
    chk({p, "_mode"},  mode_o, 0);
    chk({p, "_debug"}, debug_o, 0);
    chk({p, "_start"}, fsm_start_o, 0);
    chk({p, "_sel"},   mem_sel_o, 0);
    chk({p, "_csb"},   mem_csb_o, 1);
    chk({p, "_web"},   mem_web_o, 1);
    chk({p, "_addr"},  mem_addr_o, 0);
    chk({p, "_wdata"}, mem_wdata_o, 0);
  endtask

  // One bus transaction; caller is at a negedge with the DUT idle.
  task automatic txn(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                     input bit done_same, output logic [31:0] rdo);
    bit          base_ok, is_mem, is_sram, exp_start, seen, exp_ack;
    int          region, off, waddr, lat;
    logic [31:0] exp_rd;
    logic [63:0] exp_wd;
    base_ok = (adr[31:20] == 12'h300);
    region  = int'(adr[19:16]);
    off     = int'(adr[4:2]);
    waddr   = int'(adr[15:3]);
    is_mem  = base_ok && (region inside {[1:4]});
    exp_rd = 32'b0; exp_wd = 64'b0; is_sram = 0; exp_start = 0;
    if (is_mem) begin
      if (fsm_busy_i) m_conflict = 1;
      else if (!we) begin
        is_sram = 1;
        exp_rd = adr[2] ? ref_mem[region][waddr][63:32] : ref_mem[region][waddr][31:0];
      end else if (region == 4) begin
        if (!adr[2]) begin is_sram = 1; exp_wd = {32'b0, dat}; end
      end else if (!adr[2]) m_hold = dat;
      else begin is_sram = 1; exp_wd = {dat, m_hold}; end
      if (is_sram && we) ref_mem[region][waddr] = exp_wd;
    end else if (base_ok && region == 0) begin
      if (!we) begin
        case (off)
          0: exp_rd = {31'b0, m_mode};
          1: exp_rd = {31'b0, m_debug};
          2: exp_rd = {31'b0, m_done};
          4: exp_rd = {30'b0, m_conflict, fsm_busy_i};
          default: exp_rd = 32'b0;
        endcase
      end else begin
        case (off)
          0: m_mode = dat[0];
          1: m_debug = dat[0];
          3: exp_start = !fsm_busy_i;
          4: m_conflict = 0;
          default: ;
        endcase
      end
    end
    if (done_same) m_done = 1;
    if (exp_start) m_done = 0;
    lat = is_sram ? 2 : 1;

    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we; wbs_adr_i = adr; wbs_dat_i = dat;
    fsm_done_i = done_same;
    seen = 0; rdo = 32'b0;
    for (int k = 1; k <= lat && !seen; k++) begin
      @(negedge clk);
      fsm_done_i = 1'b0;
      exp_ack = (k == lat);
      chk("ack", wbs_ack_o, exp_ack);
      chk("csb", mem_csb_o, !(is_sram && k == 1));
      if (is_sram && k == 1) begin
        chk("sel", mem_sel_o, 4'b0001 << (region - 1));
        chk("addr", mem_addr_o, waddr);
        chk("web", mem_web_o, !we);
        if (we) chk("wdata", mem_wdata_o, exp_wd);
        last_wdata = mem_wdata_o; last_addr = mem_addr_o; last_sel = mem_sel_o;
      end
      chk("start", fsm_start_o, exp_ack && exp_start);
      chk("dat", wbs_dat_o, exp_ack ? exp_rd : 32'b0);
      chk("mode", mode_o, m_mode);
      chk("debug", debug_o, m_debug);
      if (wbs_ack_o === 1'b1) begin seen = 1; rdo = wbs_dat_o; end
    end
    for (int w = 0; w < 4 && !seen; w++) begin
      @(negedge clk);
      if (wbs_ack_o === 1'b1) seen = 1;
    end
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL ack_timeout at %0t: got no ack, expected ack within %0d cycles", $time, lat);
    end
    // Stb is still high here, so a re-sampled request would surface now.
    @(negedge clk);
    chk("ack_after", wbs_ack_o, 0);
    chk("csb_after", mem_csb_o, 1);
    chk("start_after", fsm_start_o, 0);
    chk("dat_after", wbs_dat_o, 0);
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    $display("txn we=%0d adr=%h wdat=%h rdat=%h sram=%0d busy=%0d", we, adr, dat, rdo, is_sram, fsm_busy_i);
  endtask

  task automatic pulse_done();
    fsm_done_i = 1;
    @(negedge clk);
    fsm_done_i = 0;
    m_done = 1;
  endtask

  initial begin
    logic [11:0] hi;
    int unsigned kind, r, a, h, off;
    logic [31:0] adr;
    for (int i = 0; i <= 4; i++)
      for (int j = 0; j < 64; j++) ref_mem[i][j] = dflt(i, j);
    model_reset();
    rst_n = 0; wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 4'hF;
    wbs_adr_i = 0; wbs_dat_i = 0; fsm_busy_i = 0; fsm_done_i = 0;
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst_n = 1;
    @(negedge clk);
    check_reset("post_rst");

    // Register reads after reset, then DEBUG write and readback.
    txn(0, 32'h3000_0000, 0, 0, rd); chk("lit_mode_rd", rd, 0);
    txn(0, 32'h3000_0004, 0, 0, rd); chk("lit_debug_rd", rd, 0);
    txn(0, 32'h3000_0008, 0, 0, rd); chk("lit_done_rd", rd, 0);
    txn(0, 32'h3000_0010, 0, 0, rd); chk("lit_busy_rd", rd, 0);
    txn(1, 32'h3000_0004, 1, 0, rd);
    txn(0, 32'h3000_0004, 0, 0, rd); chk("lit_debug_rb", rd, 1);

    // Leaf pack.
    txn(1, 32'h3002_0008, 32'h0123_4567, 0, rd);
    txn(1, 32'h3002_000C, 32'h89AB_CDEF, 0, rd);
    chk("lit_leaf_wdata", last_wdata, 64'h89AB_CDEF_0123_4567);
    chk("lit_leaf_addr", last_addr, 1);
    chk("lit_leaf_sel", last_sel, 4'b0010);

    // Node direct write, then a dropped upper half.
    txn(1, 32'h3004_0018, 32'h0037_0801, 0, rd);
    chk("lit_node_wdata", last_wdata, 64'h0000_0000_0037_0801);
    chk("lit_node_addr", last_addr, 3);
    txn(1, 32'h3004_001C, 32'h1234_5678, 0, rd);

    // Best word assembled through the bus, then read back upper half.
    txn(1, 32'h3003_0010, 32'h0000_07FF, 0, rd);
    txn(1, 32'h3003_0014, 32'hAAAA_BBBB, 0, rd);
    txn(0, 32'h3003_0014, 0, 0, rd); chk("lit_best_rd", rd, 32'hAAAA_BBBB);

    // Busy arbitration.
    fsm_busy_i = 1;
    txn(1, 32'h3001_0000, 32'h5555_5555, 0, rd);
    txn(0, 32'h3003_0014, 0, 0, rd); chk("lit_blocked_rd", rd, 0);
    txn(0, 32'h3000_0010, 0, 0, rd); chk("lit_busy_conflict", rd, 3);
    txn(1, 32'h3000_000C, 1, 0, rd);
    txn(1, 32'h3000_0010, 0, 0, rd);
    fsm_busy_i = 0;
    txn(0, 32'h3000_0010, 0, 0, rd); chk("lit_conflict_clr", rd, 0);

    // Start pulse, done sticky, and start beating a coincident done.
    txn(1, 32'h3000_000C, 1, 0, rd);
    pulse_done();
    txn(0, 32'h3000_0008, 0, 0, rd); chk("lit_done_set", rd, 1);
    txn(1, 32'h3000_000C, 1, 1, rd);
    txn(0, 32'h3000_0008, 0, 0, rd); chk("lit_done_start_wins", rd, 0);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) fsm_busy_i = ~fsm_busy_i;
      if ($urandom_range(0, 9) == 0) pulse_done();
      kind = $urandom_range(0, 9);
      if (kind <= 1) begin
        off = $urandom_range(0, 7);
        adr = 32'h3000_0000 | (32'(off) << 2);
      end else if (kind <= 7) begin
        r = $urandom_range(1, 4); a = $urandom_range(0, 15); h = $urandom_range(0, 1);
        adr = 32'h3000_0000 | (32'(r) << 16) | (32'(a) << 3) | (32'(h) << 2);
      end else if (kind == 8) begin
        r = $urandom_range(5, 15);
        adr = 32'h3000_0000 | (32'(r) << 16) | ($urandom & 32'h0000_FFFC);
      end else begin
        hi = 12'($urandom_range(0, 4095));
        if (hi == 12'h300) hi = 12'h301;
        adr = {hi, 20'($urandom)};
      end
      txn(1'($urandom_range(0, 1)), adr, $urandom, ($urandom_range(0, 9) == 0), rd);
    end
    fsm_busy_i = 0;

    // Reset during an ACCESS cycle.
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h3001_0008;
    @(negedge clk);
    chk("midrst_csb", mem_csb_o, 0);
    rst_n = 0;
    #1;
    check_reset("midrst");
    wbs_cyc_i = 0; wbs_stb_i = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
    repeat (2) begin
      @(negedge clk);
      chk("midrst_noack", wbs_ack_o, 0);
    end
    txn(0, 32'h3000_0004, 0, 0, rd); chk("lit_debug_after_rst", rd, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
